// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples sck/mosi/ss_n in the wb_clk_i domain,
// deserialises MOSI MSB-first and serialises queued response words onto MISO.
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sck_i,
    input  logic              mosi_i,
    input  logic              ss_n_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SEL} state_t;

    state_t                   state, state_next;
    logic [SYNC_STAGES-1:0]   sck_sync, mosi_sync, ss_n_sync;
    logic                     sck_d, ss_n_d;
    logic                     sck_s, mosi_s, ss_n_s;
    logic                     sck_rise, sck_fall, ss_rise, ss_fall;
    logic [DATA_W-1:0]        tx_shift, holding, load_word, rx_next;
    logic [DATA_W-2:0]        rx_shift;
    logic                     hold_full, reload_pend, tx_capture;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     do_select, do_deselect, do_rx, do_load, do_shift;

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_n_sync <= '1;
            sck_d     <= 1'b0;
            ss_n_d    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n_i};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_n_d    <= ss_n_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_n_s   = ss_n_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign ss_rise  =  ss_n_s & ~ss_n_d;
    assign ss_fall  = ~ss_n_s &  ss_n_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next  = state;
        do_select   = 1'b0;
        do_deselect = 1'b0;
        do_rx       = 1'b0;
        do_load     = 1'b0;
        do_shift    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = SEL;
                    do_select  = 1'b1;
                    do_load    = 1'b1;
                end
            end
            SEL: begin
                // Deselect outranks any sck edge seen in the same cycle.
                if (ss_rise) begin
                    state_next  = IDLE;
                    do_deselect = 1'b1;
                end else if (sck_rise) begin
                    do_rx = 1'b1;
                end else if (sck_fall) begin
                    if (reload_pend)          do_load  = 1'b1;
                    else if (bit_cnt != '0)   do_shift = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_capture = tx_valid_i && !hold_full;
    assign load_word  = hold_full ? holding : DEFAULT_TX;
    assign rx_next    = {rx_shift, mosi_s};

    // NOTE: data registers are reset too, so outputs are defined right after reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            holding       <= '0;
            hold_full     <= 1'b0;
            reload_pend   <= 1'b0;
            bit_cnt       <= '0;
            miso_oe_o     <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            if (do_select) begin
                miso_oe_o   <= 1'b1;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (do_deselect) begin
                miso_oe_o   <= 1'b0;
                tx_shift    <= '0;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (do_rx) begin
                rx_shift <= rx_next[DATA_W-2:0];
                if (bit_cnt == LAST_BIT) begin
                    rx_data_o   <= rx_next;
                    rx_valid_o  <= 1'b1;
                    bit_cnt     <= '0;
                    reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (do_load) begin
                tx_shift      <= load_word;
                reload_pend   <= 1'b0;
                tx_underrun_o <= !hold_full;
            end
            if (do_shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            // A word captured in a load cycle with holding empty waits for the next frame.
            if (tx_capture) begin
                holding   <= tx_data_i;
                hold_full <= 1'b1;
            end else if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign miso_o     = tx_shift[DATA_W-1];
    assign tx_ready_o = !hold_full;
    assign busy_o     = (state == SEL);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: randomized SPI sessions against a
// queue-based response model, with decoupled MISO and rx scoreboards.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic       miso, miso_oe, tx_valid = 1'b0, tx_ready;
    logic [7:0] tx_data = '0, rx_data;
    logic       rx_valid, underrun, busy;

    int n_cmp = 0, n_fail = 0;
    int underrun_seen = 0, underrun_exp = 0;
    logic [7:0] m_pend[$];
    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];

    spi_slave_responder dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .sck_i        (sck),
        .mosi_i       (mosi),
        .ss_n_i       (ss_n),
        .miso_o       (miso),
        .miso_oe_o    (miso_oe),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .tx_underrun_o(underrun),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    // Response model: one pending word is served per frame start, else 0xFF.
    function automatic logic [7:0] next_response();
        if (m_pend.size() > 0) return m_pend.pop_front();
        underrun_exp++;
        return 8'hFF;
    endfunction

    task automatic push_word(input logic [7:0] w);
        int budget = 2000;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check("tx_push_timeout", 32'(tx_ready), 32'd1);
        end else begin
            @(negedge clk);
            m_pend.push_back(w);
        end
        tx_valid = 1'b0;
    endtask

    // One ss_n session of n full frames; the session ends with sck fall and ss_n rise together.
    task automatic session(input int n, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        logic [7:0] words [3];
        words = '{w0, w1, w2};
        @(negedge clk);
        ss_n = 1'b0;
        for (int f = 0; f < n; f++) begin
            miso_q.push_back(next_response());
            rx_q.push_back(words[f]);
            for (int b = 7; b >= 0; b--) begin
                sck  = 1'b0;
                mosi = words[f][b];
                half();
                if (f == 0 && b == 7) begin
                    check("oe_in_frame", 32'(miso_oe), 32'd1);
                    check("busy_in_frame", 32'(busy), 32'd1);
                end
                sck = 1'b1;
                half();
            end
        end
        sck  = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (3) half();
        check("oe_after_deselect", 32'(miso_oe), 32'd0);
        check("busy_after_deselect", 32'(busy), 32'd0);
    endtask

    // Frame start plus nbits rising edges, without completing the frame.
    task automatic partial_start(input int nbits, input logic [7:0] w);
        @(negedge clk);
        ss_n = 1'b0;
        void'(next_response());
        for (int b = 7; b > 7 - nbits; b--) begin
            sck  = 1'b0;
            mosi = w[b];
            half();
            sck = 1'b1;
            half();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // MISO monitor: master samples on sck rise; a deselect drops any partial frame.
    initial begin
        logic [7:0] bits = '0;
        int cnt = 0;
        forever begin
            @(posedge sck or posedge ss_n);
            if (ss_n) begin
                cnt = 0;
            end else begin
                bits = {bits[6:0], miso};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (miso_q.size() == 0) check("miso_unexpected_frame", 32'(bits), 32'hFFFF);
                    else check("miso_frame", 32'(bits), 32'(miso_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (rx_q.size() == 0) check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
                else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
            if (underrun) underrun_seen++;
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_ready", 32'(tx_ready), 32'd1);
        check("idle_oe", 32'(miso_oe), 32'd0);

        push_word(8'hA5);
        check("ready_after_queue", 32'(tx_ready), 32'd0);
        session(1, 8'h3C, 8'h00, 8'h00);
        check("ready_after_frame", 32'(tx_ready), 32'd1);
        check("underrun_a5", 32'(underrun_seen), 32'(underrun_exp));

        session(2, 8'h01, 8'h80, 8'h00);
        check("underrun_two_default", 32'(underrun_seen), 32'(underrun_exp));

        push_word(8'h11);
        fork
            session(2, 8'h96, 8'h69, 8'h00);
            push_word(8'h22);
        join
        check("underrun_burst", 32'(underrun_seen), 32'(underrun_exp));

        partial_start(5, 8'hE7);
        sck = 1'b0;
        half();
        ss_n = 1'b1;
        repeat (3) half();
        check("oe_after_abort", 32'(miso_oe), 32'd0);
        session(1, 8'hC3, 8'h00, 8'h00);

        partial_start(3, 8'h5B);
        push_word(8'h77);
        @(negedge clk);
        rst  = 1'b1;
        sck  = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        m_pend.delete();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        session(1, 8'h5A, 8'h00, 8'h00);
        check("underrun_after_reset", 32'(underrun_seen), 32'(underrun_exp));

        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                push_word(w);
            end
            session(int'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        check("underrun_random", 32'(underrun_seen), 32'(underrun_exp));

        repeat (20) @(negedge clk);
        check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
